// File: rtl/constraint_sample_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// constraint_sample_pkg
//
// Shared definitions for the constraint sampling sequencer:
//   - field widths and bit offsets of the packed candidate
//     {var_4, var_3, var_2, var_1, var_0}, var_0 in the low bits
//   - sample_state_e, the sequencer state type
//   - LFSR feedback tap mask and the fallback seed
//
// No ports; imported by the interface, the LFSR and the top level.
// ---------------------------------------------------------------------------
package constraint_sample_pkg;

    localparam int VAR0_W = 13;
    localparam int VAR1_W = 13;
    localparam int VAR2_W = 14;
    localparam int VAR3_W = 14;
    localparam int VAR4_W = 8;

    localparam int VAR0_OFF = 0;
    localparam int VAR1_OFF = VAR0_OFF + VAR0_W;
    localparam int VAR2_OFF = VAR1_OFF + VAR1_W;
    localparam int VAR3_OFF = VAR2_OFF + VAR2_W;
    localparam int VAR4_OFF = VAR3_OFF + VAR3_W;

    // Full candidate width falls out of the field layout (62 bits).
    localparam int CAND_W = VAR4_OFF + VAR4_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_CHECK,
        S_HOLD,
        S_FAIL
    } sample_state_e;

    // Taps 62,61,6,5 (1-based) are state bits 61,60,5,4.
    localparam logic [CAND_W-1:0] LFSR_TAP_MASK = {2'b11, 54'd0, 2'b11, 4'd0};

    localparam logic [CAND_W-1:0] SEED_DEFAULT = CAND_W'(1);

endpackage

// File: rtl/constraint_sample_ctrl_if.sv
// ---------------------------------------------------------------------------
// constraint_sample_ctrl_if
//
// Bundles the two busses of the sequencer:
//   - checker side:  cand_o (candidate out), sat_i (all constraints met)
//   - consumer side: sol_valid_o / sol_ready_i handshake, sol_data_o
//
// master : the sequencer (drives candidate and solution)
// slave  : the environment (checker result and consumer ready)
// ---------------------------------------------------------------------------
interface constraint_sample_ctrl_if
    import constraint_sample_pkg::*;
#(
    parameter int VEC_W = CAND_W
);

    logic [VEC_W-1:0] cand_o;
    logic             sat_i;
    logic             sol_valid_o;
    logic             sol_ready_i;
    logic [VEC_W-1:0] sol_data_o;

    modport master (
        output cand_o,
        output sol_valid_o,
        output sol_data_o,
        input  sat_i,
        input  sol_ready_i
    );

    modport slave (
        input  cand_o,
        input  sol_valid_o,
        input  sol_data_o,
        output sat_i,
        output sol_ready_i
    );

endinterface

// File: rtl/constraint_sample_ctrl_lfsr_gen.sv
// ---------------------------------------------------------------------------
// lfsr_gen
//
// Fibonacci LFSR with parallel load and a zero guard.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (state <= SEED)
//   load_i       load load_val_i (SEED when load_val_i is zero)
//   load_val_i   value to load
//   step_i       advance one step
//   next_o       value the register takes on the next step
// ---------------------------------------------------------------------------
module lfsr_gen #(
    parameter int               WIDTH = 62,
    parameter logic [WIDTH-1:0] TAPS  = '0,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] shifted;

    // Feedback is the parity of the tapped bits, shifted in at bit 0.
    // An all-zero register is the one lock-up state; it is replaced by SEED.
    always_comb begin
        shifted = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        next_o  = (shifted == '0) ? SEED : shifted;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else if (load_i) begin
            state_q <= (load_val_i == '0) ? SEED : load_val_i;
        end else if (step_i) begin
            state_q <= next_o;
        end
    end

endmodule

// File: rtl/constraint_sample_ctrl.sv
// ---------------------------------------------------------------------------
// constraint_sample_ctrl
//
// Drives pseudo-random candidates into a combinational constraint checker,
// samples its single "all satisfied" bit and hands satisfying candidates to
// a consumer over valid/ready. Each solution gets at most MAX_TRIES
// candidates; running out ends the run with a done_o + fail_o pulse.
// Every attempt takes two cycles: GEN (new candidate) then CHECK (sample).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         start a run (IDLE only); captures seed_i, num_samples_i
//   abort_i         cancel a run in any non-IDLE state, no done/fail pulse
//   seed_i          LFSR seed, zero selects DEFAULT_SEED
//   num_samples_i   solutions requested, zero means one
//   bus             checker and consumer busses (master modport)
//   busy_o          high outside IDLE
//   done_o          one-cycle pulse at the end of a run
//   fail_o          one-cycle pulse with done_o when the attempt limit hits
//   attempts_o      candidates tried for the current solution
//   samples_o       solutions accepted so far in this run
//
// Build option SAMPLE_STATS_EN adds lifetime counters:
//   total_tries_o   GEN steps across all runs, saturating
//   total_fails_o   number of FAIL entries, saturating
// Both clear only on rst_n.
// ---------------------------------------------------------------------------
module constraint_sample_ctrl
    import constraint_sample_pkg::*;
#(
    parameter int                VEC_W        = CAND_W,
    parameter int                MAX_TRIES    = 1000,
    parameter int                TRY_W        = 16,
    parameter int                CNT_W        = 8,
    parameter logic [VEC_W-1:0]  DEFAULT_SEED = SEED_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [VEC_W-1:0]          seed_i,
    input  logic [CNT_W-1:0]          num_samples_i,
    constraint_sample_ctrl_if.master  bus,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      fail_o,
    output logic [TRY_W-1:0]          attempts_o,
    output logic [CNT_W-1:0]          samples_o
`ifdef SAMPLE_STATS_EN
   ,output logic [31:0]               total_tries_o,
    output logic [15:0]               total_fails_o
`endif
);

    sample_state_e    state_q;
    logic [VEC_W-1:0] cand_q;
    logic             sol_valid_q;
    logic [CNT_W-1:0] target_q;

    logic [VEC_W-1:0] lfsr_next;
    logic             lfsr_load;
    logic             lfsr_step;
    logic             abort_run;
    logic             accept;
    logic             limit_hit;
    logic             fail_entry;
    logic [CNT_W-1:0] samples_inc;

    // The solution is the candidate itself; holding cand_q in HOLD keeps
    // both stable until the consumer takes it.
    assign bus.cand_o      = cand_q;
    assign bus.sol_data_o  = cand_q;
    assign bus.sol_valid_o = sol_valid_q;

    // abort_i is ignored in IDLE so that start_i wins when both are high.
    assign abort_run   = abort_i && (state_q != S_IDLE);
    assign accept      = sol_valid_q && bus.sol_ready_i;
    assign limit_hit   = (attempts_o >= TRY_W'(MAX_TRIES));
    assign fail_entry  = (state_q == S_CHECK) && !abort_run && !bus.sat_i && limit_hit;
    assign samples_inc = samples_o + CNT_W'(1);
    assign lfsr_load   = (state_q == S_IDLE) && start_i;
    assign lfsr_step   = (state_q == S_GEN) && !abort_run;

    lfsr_gen #(
        .WIDTH (VEC_W),
        .TAPS  (LFSR_TAP_MASK),
        .SEED  (DEFAULT_SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (lfsr_load),
        .load_val_i (seed_i),
        .step_i     (lfsr_step),
        .next_o     (lfsr_next)
    );

    // Sequencer. Outputs are registered on the transition that enters a
    // state, so sol_valid_o is high for exactly the HOLD cycles and the
    // done/fail pulse lines up with the single FAIL cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cand_q      <= '0;
            sol_valid_q <= 1'b0;
            target_q    <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            fail_o      <= 1'b0;
            attempts_o  <= '0;
            samples_o   <= '0;
        end else begin
            done_o <= 1'b0;
            fail_o <= 1'b0;
            if (abort_run) begin
                // A handshake finishing in the abort cycle is still counted.
                if (accept) begin
                    samples_o <= samples_inc;
                end
                sol_valid_q <= 1'b0;
                busy_o      <= 1'b0;
                state_q     <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            attempts_o <= '0;
                            samples_o  <= '0;
                            target_q   <= (num_samples_i == '0) ? CNT_W'(1) : num_samples_i;
                            busy_o     <= 1'b1;
                            state_q    <= S_GEN;
                        end
                    end
                    S_GEN: begin
                        cand_q <= lfsr_next;
                        if (attempts_o != '1) begin
                            attempts_o <= attempts_o + TRY_W'(1);
                        end
                        state_q <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (bus.sat_i) begin
                            sol_valid_q <= 1'b1;
                            state_q     <= S_HOLD;
                        end else if (limit_hit) begin
                            done_o  <= 1'b1;
                            fail_o  <= 1'b1;
                            state_q <= S_FAIL;
                        end else begin
                            state_q <= S_GEN;
                        end
                    end
                    S_HOLD: begin
                        if (accept) begin
                            sol_valid_q <= 1'b0;
                            samples_o   <= samples_inc;
                            attempts_o  <= '0;
                            if (samples_inc == target_q) begin
                                done_o  <= 1'b1;
                                busy_o  <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                state_q <= S_GEN;
                            end
                        end
                    end
                    S_FAIL: begin
                        busy_o  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        sol_valid_q <= 1'b0;
                        busy_o      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SAMPLE_STATS_EN
    // Lifetime counters survive across runs and aborts; only rst_n clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_tries_o <= '0;
            total_fails_o <= '0;
        end else begin
            if (lfsr_step && (total_tries_o != '1)) begin
                total_tries_o <= total_tries_o + 32'd1;
            end
            if (fail_entry && (total_fails_o != '1)) begin
                total_fails_o <= total_fails_o + 16'd1;
            end
        end
    end
`else
    logic unused_fail_entry;
    assign unused_fail_entry = fail_entry;
`endif

endmodule

// File: tb/tb_constraint_sample_ctrl.sv
// ---------------------------------------------------------------------------
// tb_constraint_sample_ctrl
//
// Bench for constraint_sample_ctrl (MAX_TRIES = 8). A stand-in checker
// derives sat_i from the candidate; a protocol-level model predicts every
// output and is compared on each falling clock edge. Directed scenarios
// add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_constraint_sample_ctrl;

    localparam int VW   = 62;
    localparam int CW   = 8;
    localparam int TW   = 16;
    localparam int MAXT = 8;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          start_i  = 1'b0;
    logic          abort_i  = 1'b0;
    logic [VW-1:0] seed_i   = '0;
    logic [CW-1:0] num_i    = '0;
    logic          readyDrv = 1'b0;
    logic          busy;
    logic          done;
    logic          fail;
    logic [TW-1:0] attempts;
    logic [CW-1:0] samples;
`ifdef SAMPLE_STATS_EN
    logic [31:0]   total_tries;
    logic [15:0]   total_fails;
`endif

    int satMode = 0;
    bit satRand = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [VW-1:0] accepted[$];
    bit            prevAccept;

    constraint_sample_ctrl_if #(.VEC_W(VW)) bus();

    constraint_sample_ctrl #(
        .VEC_W     (VW),
        .MAX_TRIES (MAXT),
        .TRY_W     (TW),
        .CNT_W     (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .seed_i        (seed_i),
        .num_samples_i (num_i),
        .bus           (bus),
        .busy_o        (busy),
        .done_o        (done),
        .fail_o        (fail),
        .attempts_o    (attempts),
        .samples_o     (samples)
`ifdef SAMPLE_STATS_EN
       ,.total_tries_o (total_tries),
        .total_fails_o (total_fails)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in checker: mode 0 never satisfied, 1 always, 2 random bit.
    function automatic logic checkerResult(input logic [VW-1:0] cand, input int mode, input bit rnd);
        if (mode == 0) return 1'b0;
        if (mode == 1) return (cand != '0);
        return rnd;
    endfunction

    assign bus.sat_i       = checkerResult(bus.cand_o, satMode, satRand);
    assign bus.sol_ready_i = readyDrv;

    // One Fibonacci step, taps 62,61,6,5 counted from 1.
    function automatic logic [VW-1:0] lfsrAdvance(input logic [VW-1:0] v);
        logic [VW-1:0] n;
        n = {v[VW-2:0], v[61] ^ v[60] ^ v[5] ^ v[4]};
        if (n == '0) n = VW'(1);
        return n;
    endfunction

    // ---------------- behavioural model ----------------
    logic [VW-1:0] exp_cand;
    logic          exp_valid;
    logic          exp_busy;
    logic          exp_done;
    logic          exp_fail;
    int            exp_attempts;
    int            exp_samples;
    longint        exp_tries;
    int            exp_fails;
    int            m_target;
    logic [VW-1:0] m_lfsr;
    bit            drawDue;
    bit            judgeDue;
    bit            reportDue;
    bit            satNow;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_cand = '0; exp_valid = 0; exp_busy = 0; exp_done = 0; exp_fail = 0;
            exp_attempts = 0; exp_samples = 0; exp_tries = 0; exp_fails = 0;
            m_target = 0; m_lfsr = VW'(1); drawDue = 0; judgeDue = 0; reportDue = 0;
        end else begin
            satNow   = checkerResult(exp_cand, satMode, satRand);
            exp_done = 0;
            exp_fail = 0;
            if (!exp_busy) begin
                if (start_i) begin
                    m_lfsr       = (seed_i == '0) ? VW'(1) : seed_i;
                    exp_attempts = 0;
                    exp_samples  = 0;
                    m_target     = (num_i == 0) ? 1 : int'(num_i);
                    exp_busy     = 1;
                    drawDue      = 1;
                end
            end else if (abort_i) begin
                if (exp_valid && readyDrv) exp_samples++;
                exp_busy = 0; exp_valid = 0; drawDue = 0; judgeDue = 0; reportDue = 0;
            end else if (drawDue) begin
                m_lfsr   = lfsrAdvance(m_lfsr);
                exp_cand = m_lfsr;
                if (exp_attempts < 65535) exp_attempts++;
                if (exp_tries < 64'hFFFF_FFFF) exp_tries++;
                drawDue  = 0;
                judgeDue = 1;
            end else if (judgeDue) begin
                judgeDue = 0;
                if (satNow) begin
                    exp_valid = 1;
                end else if (exp_attempts >= MAXT) begin
                    exp_done = 1; exp_fail = 1; reportDue = 1;
                    if (exp_fails < 65535) exp_fails++;
                end else begin
                    drawDue = 1;
                end
            end else if (exp_valid) begin
                if (readyDrv) begin
                    exp_samples++;
                    exp_attempts = 0;
                    exp_valid    = 0;
                    if (exp_samples == m_target) begin
                        exp_done = 1;
                        exp_busy = 0;
                    end else begin
                        drawDue = 1;
                    end
                end
            end else if (reportDue) begin
                reportDue = 0;
                exp_busy  = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("cand_o",      64'(bus.cand_o),      64'(exp_cand));
            checkOutput("sol_data_o",  64'(bus.sol_data_o),  64'(exp_cand));
            checkOutput("sol_valid_o", 64'(bus.sol_valid_o), 64'(exp_valid));
            checkOutput("busy_o",      64'(busy),            64'(exp_busy));
            checkOutput("done_o",      64'(done),            64'(exp_done));
            checkOutput("fail_o",      64'(fail),            64'(exp_fail));
            checkOutput("attempts_o",  64'(attempts),        64'(exp_attempts));
            checkOutput("samples_o",   64'(samples),         64'(exp_samples));
`ifdef SAMPLE_STATS_EN
            checkOutput("total_tries_o", 64'(total_tries),   64'(exp_tries));
            checkOutput("total_fails_o", 64'(total_fails),   64'(exp_fails));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit start, input bit abort, input bit ready,
                                 input logic [VW-1:0] seed, input logic [CW-1:0] num, input int mode);
        start_i  = start;
        abort_i  = abort;
        readyDrv = ready;
        seed_i   = seed;
        num_i    = num;
        satMode  = mode;
        satRand  = ($urandom_range(0, 3) == 0);
        tick();
    endtask

    task automatic runUntilDone(input int budget, input bit ready, input int mode);
        int used;
        used = 0;
        while (!done && used < budget) begin
            if (bus.sol_valid_o && ready) accepted.push_back(bus.sol_data_o);
            prevAccept = bus.sol_valid_o && ready;
            applyStimulus(0, 0, ready, seed_i, num_i, mode);
            used++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: got no done_o, expected one within %0d cycles", budget);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cand"},     64'(bus.cand_o),      64'd0);
        checkOutput({tag, "_data"},     64'(bus.sol_data_o),  64'd0);
        checkOutput({tag, "_valid"},    64'(bus.sol_valid_o), 64'd0);
        checkOutput({tag, "_busy"},     64'(busy),            64'd0);
        checkOutput({tag, "_done"},     64'(done),            64'd0);
        checkOutput({tag, "_fail"},     64'(fail),            64'd0);
        checkOutput({tag, "_attempts"}, 64'(attempts),        64'd0);
        checkOutput({tag, "_samples"},  64'(samples),         64'd0);
`ifdef SAMPLE_STATS_EN
        checkOutput({tag, "_tries"},    64'(total_tries),     64'd0);
        checkOutput({tag, "_fails"},    64'(total_fails),     64'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int failCount;
        int doneCount;
        int failCycle;
        int zeros;
        int dupes;
        logic [VW-1:0] held;
        logic [VW-1:0] seedVal;
        bit seen[logic [VW-1:0]];

        // Reset
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        checkAllZero("reset");

        // Always satisfied, seed 1, three solutions, consumer always ready
        accepted.delete();
        applyStimulus(1, 0, 1, VW'(1), 8'd3, 1);
        applyStimulus(0, 0, 1, VW'(1), 8'd3, 1);
        checkOutput("valid_before_hit", 64'(bus.sol_valid_o), 64'd0);
        applyStimulus(0, 0, 1, VW'(1), 8'd3, 1);
        checkOutput("first_hit_latency", 64'(bus.sol_valid_o), 64'd1);
        runUntilDone(40, 1, 1);
        checkOutput("three_accepts", 64'(accepted.size()), 64'd3);
        if (accepted.size() == 3) begin
            checkOutput("sol0", 64'(accepted[0]), 64'h2);
            checkOutput("sol1", 64'(accepted[1]), 64'h4);
            checkOutput("sol2", 64'(accepted[2]), 64'h8);
        end
        checkOutput("done_after_accept", 64'(prevAccept), 64'd1);
        checkOutput("samples_three", 64'(samples), 64'd3);
        checkOutput("no_fail_on_success", 64'(fail), 64'd0);
        applyStimulus(0, 0, 1, VW'(1), 8'd3, 1);

        // Never satisfied: attempt limit
        failCount = 0; doneCount = 0; failCycle = -1;
        applyStimulus(1, 0, 1, VW'(62'h1234), 8'd1, 0);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 2)  checkOutput("attempts_first", 64'(attempts), 64'd1);
            if (cyc == 16) checkOutput("attempts_limit", 64'(attempts), 64'(MAXT));
            if (cyc == 18) checkOutput("busy_after_fail", 64'(busy), 64'd0);
            if (fail) begin failCount++; failCycle = cyc; end
            if (done) doneCount++;
            applyStimulus(0, 0, 1, VW'(62'h1234), 8'd1, 0);
        end
        checkOutput("fail_pulse_count", 64'(failCount), 64'd1);
        checkOutput("done_pulse_count", 64'(doneCount), 64'd1);
        checkOutput("fail_pulse_cycle", 64'(failCycle), 64'd17);

        // Consumer stall with a held solution
        seedVal = VW'({$urandom(), $urandom()}) | VW'(1);
        applyStimulus(1, 0, 0, seedVal, 8'd1, 1);
        applyStimulus(0, 0, 0, seedVal, 8'd1, 1);
        applyStimulus(0, 0, 0, seedVal, 8'd1, 1);
        held = bus.sol_data_o;
        checkOutput("stall_first_solution", 64'(held), 64'(lfsrAdvance(seedVal)));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, seedVal, 8'd1, 1);
            checkOutput("stall_data_stable", 64'(bus.sol_data_o), 64'(held));
            checkOutput("stall_valid_held", 64'(bus.sol_valid_o), 64'd1);
        end
        applyStimulus(0, 0, 1, seedVal, 8'd1, 1);
        checkOutput("stall_done", 64'(done), 64'd1);
        checkOutput("stall_samples", 64'(samples), 64'd1);
        applyStimulus(0, 0, 0, seedVal, 8'd1, 1);

        // Zero seed: default seed, 200 solutions without lock-up
        accepted.delete();
        applyStimulus(1, 0, 1, '0, 8'd200, 1);
        applyStimulus(0, 0, 1, '0, 8'd200, 1);
        checkOutput("default_seed_first", 64'(bus.cand_o), 64'h2);
        runUntilDone(700, 1, 1);
        checkOutput("two_hundred_accepts", 64'(accepted.size()), 64'd200);
        checkOutput("samples_two_hundred", 64'(samples), 64'd200);
        zeros = 0; dupes = 0;
        foreach (accepted[i]) begin
            if (accepted[i] == '0) zeros++;
            if (seen.exists(accepted[i])) dupes++;
            seen[accepted[i]] = 1'b1;
        end
        checkOutput("lfsr_zero_states", 64'(zeros), 64'd0);
        checkOutput("lfsr_repeats", 64'(dupes), 64'd0);
        applyStimulus(0, 0, 1, '0, 8'd200, 1);

        // Abort while holding a solution, then a normal run
        applyStimulus(1, 0, 0, VW'(62'h77), 8'd2, 1);
        applyStimulus(0, 0, 0, VW'(62'h77), 8'd2, 1);
        applyStimulus(0, 0, 0, VW'(62'h77), 8'd2, 1);
        checkOutput("abort_in_hold", 64'(bus.sol_valid_o), 64'd1);
        applyStimulus(0, 1, 0, VW'(62'h77), 8'd2, 1);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_valid", 64'(bus.sol_valid_o), 64'd0);
        checkOutput("abort_no_done", 64'(done), 64'd0);
        checkOutput("abort_samples", 64'(samples), 64'd0);
        applyStimulus(0, 0, 1, VW'(62'h77), 8'd1, 1);
        applyStimulus(1, 0, 1, VW'(62'h77), 8'd1, 1);
        runUntilDone(20, 1, 1);
        checkOutput("restart_samples", 64'(samples), 64'd1);
        applyStimulus(0, 0, 1, VW'(62'h77), 8'd1, 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit st;
            bit ab;
            st = busy ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 59) == 0);
            seedVal = ($urandom_range(0, 7) == 0) ? '0 : VW'({$urandom(), $urandom()});
            applyStimulus(st, ab, 1'($urandom_range(0, 1)), seedVal,
                          CW'($urandom_range(0, 3)), 2);
        end
        applyStimulus(0, 1, 1, '0, 8'd1, 2);
        applyStimulus(0, 0, 1, '0, 8'd1, 2);

        // Asynchronous reset in the middle of CHECK
        applyStimulus(1, 0, 1, VW'(62'h5A5A), 8'd1, 0);
        applyStimulus(0, 0, 1, VW'(62'h5A5A), 8'd1, 0);
        checkOutput("pre_reset_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(0, 0, 1, '0, 8'd1, 0);
        applyStimulus(0, 0, 1, '0, 8'd1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
